// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder: one bit pair per clock through a pair of chained half adders,
// LSB first, with the sum presented on a valid/ready handshake until accepted.
//
// state | meaning
// IDLE  | waiting for operands, o_ready=1
// RUN   | shifting one bit per clock through the adder, o_busy=1
// DONE  | result held on o_sum/o_cout, o_valid=1 until i_ready

module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic             o_busy,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic             carry;
    logic [CW-1:0]    bit_cnt;

    logic             ha1_s;
    logic             ha1_c;
    logic             ha2_s;
    logic             ha2_c;
    logic             carry_nxt;
    logic [WIDTH:0]   sum_cat;
    logic             last_bit;

    assign ha1_s     = a_sr[0] ^ b_sr[0];
    assign ha1_c     = a_sr[0] & b_sr[0];
    assign ha2_s     = ha1_s ^ carry;
    assign ha2_c     = ha1_s & carry;
    assign carry_nxt = ha1_c | ha2_c;
    // Concatenation keeps the shift legal for WIDTH=1, where o_sum[WIDTH-1:1] is empty.
    assign sum_cat   = {ha2_s, o_sum};
    assign last_bit  = (bit_cnt == LAST_BIT);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_busy    = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                o_ready = 1'b1;
                if (i_valid) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                o_busy = 1'b1;
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                o_valid = 1'b1;
                if (i_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            carry   <= 1'b0;
            bit_cnt <= '0;
            o_sum   <= '0;
            o_cout  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        a_sr    <= i_a;
                        b_sr    <= i_b;
                        carry   <= i_cin;
                        bit_cnt <= '0;
                        o_sum   <= '0;
                    end
                end
                RUN: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    carry   <= carry_nxt;
                    o_sum   <= sum_cat[WIDTH:1];
                    bit_cnt <= bit_cnt + CW'(1);
                    if (last_bit) begin
                        o_cout <= carry_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: an 8-bit instance for directed and
// random operations, and a 4-bit instance swept over every operand combination.

module tb_serial_adder_ctrl;

    logic       clk;
    logic       rst_n;

    logic       v8, rdy8, cin8, busy8, ov8, ir8, cout8;
    logic [7:0] a8, b8, sum8;

    logic       v4, rdy4, cin4, busy4, ov4, ir4, cout4;
    logic [3:0] a4, b4, sum4;

    int total;
    int bad;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v8), .o_ready(rdy8),
        .i_a(a8), .i_b(b8), .i_cin(cin8), .o_busy(busy8), .o_valid(ov8),
        .i_ready(ir8), .o_sum(sum8), .o_cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(v4), .o_ready(rdy4),
        .i_a(a4), .i_b(b4), .i_cin(cin4), .o_busy(busy4), .o_valid(ov4),
        .i_ready(ir4), .o_sum(sum4), .o_cout(cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one operation on the 8-bit instance and wait for o_valid; leaves it in DONE.
    task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic c,
                          output int lat);
        v8 = 1'b1; a8 = a; b8 = b; cin8 = c;
        tick();
        v8 = 1'b0; a8 = $urandom; b8 = $urandom; cin8 = $urandom;
        lat = 0;
        while (!ov8 && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic release8();
        ir8 = 1'b1;
        tick();
        ir8 = 1'b0;
    endtask

    task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic c);
        int       lat;
        logic [8:0] ref_v;
        ref_v = 9'(a) + 9'(b) + 9'(c);
        check({tag, "_ready"}, 64'(rdy8), 64'(1));
        start8(a, b, c, lat);
        check({tag, "_lat"}, 64'(lat), 64'(8));
        check({tag, "_res"}, 64'({cout8, sum8}), 64'(ref_v));
        release8();
        check({tag, "_vdrop"}, 64'(ov8), 64'(0));
    endtask

    initial begin
        int         lat;
        logic [7:0] ra, rb;
        logic       rc;
        logic [4:0] ref4;

        total = 0; bad = 0;
        rst_n = 1'b0;
        v8 = 0; a8 = 0; b8 = 0; cin8 = 0; ir8 = 0;
        v4 = 0; a4 = 0; b4 = 0; cin4 = 0; ir4 = 0;
        repeat (2) tick();

        check("rst_ready", 64'(rdy8), 64'(1));
        check("rst_busy",  64'(busy8), 64'(0));
        check("rst_valid", 64'(ov8), 64'(0));
        check("rst_sum",   64'(sum8), 64'(0));
        check("rst_cout",  64'(cout8), 64'(0));
        rst_n = 1'b1;
        tick();

        op8("t2", 8'h0F, 8'h01, 1'b0);
        op8("t3a", 8'hFF, 8'h01, 1'b0);
        op8("t3b", 8'hFF, 8'hFF, 1'b1);

        // Result must hold in DONE while the consumer stalls, and an operand
        // pulse during RUN must neither corrupt the sum nor start a second op.
        v8 = 1'b1; a8 = 8'h3C; b8 = 8'h5A; cin8 = 1'b1;
        tick();
        v8 = 1'b0;
        tick();
        check("t4_busy", 64'(busy8), 64'(1));
        check("t4_rdy_run", 64'(rdy8), 64'(0));
        v8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0;
        tick();
        v8 = 1'b0;
        lat = 2;
        while (!ov8 && lat < 40) begin
            tick();
            lat++;
        end
        check("t4_lat", 64'(lat), 64'(8));
        for (int i = 0; i < 5; i++) begin
            check("t4_hold_v", 64'(ov8), 64'(1));
            check("t4_hold_s", 64'({cout8, sum8}), 64'(9'h3C + 9'h5A + 9'h1));
            v8 = 1'b1;
            tick();
        end
        v8 = 1'b0;
        release8();
        check("t4_idle_rdy", 64'(rdy8), 64'(1));
        check("t4_no_2nd", 64'(busy8), 64'(0));
        check("t4_keep_sum", 64'(sum8), 64'(8'h97));

        // Abort in the middle of RUN.
        v8 = 1'b1; a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0;
        tick();
        v8 = 1'b0;
        repeat (3) tick();
        check("t5_busy", 64'(busy8), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t5_ready", 64'(rdy8), 64'(1));
        check("t5_busy0", 64'(busy8), 64'(0));
        check("t5_valid", 64'(ov8), 64'(0));
        check("t5_sum",   64'(sum8), 64'(0));
        check("t5_cout",  64'(cout8), 64'(0));
        tick();
        rst_n = 1'b1;
        tick();
        op8("t5_after", 8'h03, 8'h04, 1'b0);

        for (int i = 0; i < 25; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            op8("rand8", ra, rb, rc);
        end

        // 4-bit sweep of all a/b/cin combinations.
        for (int k = 0; k < 512; k++) begin
            v4 = 1'b1; a4 = 4'(k); b4 = 4'(k >> 4); cin4 = 1'(k >> 8);
            ref4 = 5'(k & 15) + 5'((k >> 4) & 15) + 5'((k >> 8) & 1);
            tick();
            v4 = 1'b0;
            lat = 0;
            while (!ov4 && lat < 20) begin
                tick();
                lat++;
            end
            if (lat != 4) check("w4_lat", 64'(lat), 64'(4));
            check("w4_res", 64'({cout4, sum4}), 64'(ref4));
            ir4 = 1'b1;
            tick();
            ir4 = 1'b0;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
